// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit-datapath front end of the 16-bit ALU.
// States, opcode ranges and ALU width used by alu_operand_seq.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [7:0] CLR_CMP = 8'h50;
  localparam logic [7:0] MODE_LO = 8'h51;
  localparam logic [7:0] MODE_HI = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MODE,
    S_SETTLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_OUT
  } SeqState;

  function automatic logic is_mode_op(input logic [7:0] ir);
    return (ir >= MODE_LO) && (ir <= MODE_HI);
  endfunction

endpackage

// File: rtl/alu_operand_seq.sv
// Byte-stream operand collector / result drainer in front of the 16-bit ALU.
// Optional watchdog on the ALU handshake: define ALU_TIMEOUT_EN.
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int         OPERAND_BYTES  = 2,
  parameter logic [7:0] IDLE_IR        = 8'h00,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           cmd_ir,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [7:0]           din,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_data,
  output logic                 res_carry,
  output logic                 res_over,
  output logic                 res_cmp,
  output logic                 res_err,
  output logic                 alu_start,
  input  logic                 alu_done,
  output logic [7:0]           alu_ir,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic                 alu_oe,
  output logic                 alu_carryin,
  input  logic [ALU_WIDTH-1:0] alu_aluout,
  input  logic                 alu_carryout,
  input  logic                 alu_overout,
  input  logic                 alu_cmpo
);

  if (OPERAND_BYTES < 1 || OPERAND_BYTES > 2) begin : g_bad_bytes
    $error("OPERAND_BYTES must be 1 or 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must fit the 7-bit watchdog");
  end

  localparam logic [2:0] NB        = 3'(OPERAND_BYTES);
  localparam logic [2:0] LAST_LOAD = 3'(2 * OPERAND_BYTES - 1);
  localparam logic [2:0] LAST_OUT  = 3'(OPERAND_BYTES - 1);

  SeqState state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] op_q, op_d, ir_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic carry_q, carry_d, over_q, over_d, cmp_q, cmp_d;
  logic hi_byte;

  logic cmd_ready_q, din_ready_q, res_valid_q;
  logic alu_start_q, alu_oe_q;
  logic [7:0] alu_ir_q;

`ifdef ALU_TIMEOUT_EN
  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] tmo_q, tmo_d;
  logic err_q, err_d;
`endif

  // With two-byte operands the low counter bit picks the byte lane.
  assign hi_byte = (OPERAND_BYTES == 2) && cnt_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    over_d  = over_q;
    cmp_d   = cmp_q;
`ifdef ALU_TIMEOUT_EN
    tmo_d = tmo_q;
    err_d = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_ir;
          cnt_d   = 3'd0;
          state_d = is_mode_op(cmd_ir) ? S_MODE : S_LOAD;
        end
      end
      S_MODE: state_d = S_SETTLE;
      S_SETTLE: begin
        if (alu_done) state_d = S_IDLE;
      end
      S_LOAD: begin
        if (din_valid) begin
          if (cnt_q < NB) begin
            if (hi_byte) a_d[15:8] = din;
            else         a_d[7:0]  = din;
          end else begin
            if (hi_byte) b_d[15:8] = din;
            else         b_d[7:0]  = din;
          end
          if (cnt_q == LAST_LOAD) begin
            cnt_d   = 3'd0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_ISSUE: begin
        cmp_d   = 1'b0;
        state_d = S_WAIT_ACK;
`ifdef ALU_TIMEOUT_EN
        tmo_d = 7'd0;
        err_d = 1'b0;
`endif
      end
      S_WAIT_ACK: begin
        if (!alu_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cmp_d = cmp_q | alu_cmpo;
        if (alu_done) begin
          carry_d = alu_carryout;
          over_d  = alu_overout;
          cnt_d   = 3'd0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (cnt_q == LAST_OUT) begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ALU_TIMEOUT_EN
    if (state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) begin
      if (state_d == state_q && tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        cnt_d   = 3'd0;
        state_d = S_OUT;
      end else begin
        tmo_d = tmo_q + 7'd1;
      end
    end
`endif
  end

  always_comb begin
    unique case (state_d)
      S_MODE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_OUT: ir_d = op_d;
      default: ir_d = IDLE_IR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      op_q        <= 8'h00;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      carry_q     <= 1'b0;
      over_q      <= 1'b0;
      cmp_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      din_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      alu_start_q <= 1'b0;
      alu_oe_q    <= 1'b0;
      alu_ir_q    <= IDLE_IR;
`ifdef ALU_TIMEOUT_EN
      tmo_q <= 7'd0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      over_q      <= over_d;
      cmp_q       <= cmp_d;
      cmd_ready_q <= (state_d == S_IDLE);
      din_ready_q <= (state_d == S_LOAD);
      res_valid_q <= (state_d == S_OUT);
      alu_start_q <= (state_d == S_ISSUE);
      alu_oe_q    <= (state_d == S_OUT);
      alu_ir_q    <= ir_d;
`ifdef ALU_TIMEOUT_EN
      tmo_q <= tmo_d;
      err_q <= err_d;
`endif
    end
  end

  always_comb begin
    res_data = 8'h00;
    if (res_valid_q) res_data = cnt_q[0] ? alu_aluout[15:8] : alu_aluout[7:0];
`ifdef ALU_TIMEOUT_EN
    if (err_q) res_data = 8'h00;
`endif
  end

`ifdef ALU_TIMEOUT_EN
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign din_ready   = din_ready_q;
  assign res_valid   = res_valid_q;
  assign res_carry   = carry_q;
  assign res_over    = over_q;
  assign res_cmp     = cmp_q;
  assign alu_start   = alu_start_q;
  assign alu_ir      = alu_ir_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_oe      = alu_oe_q;
  assign alu_carryin = carry_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a small behavioural ALU.
// Timeout scenario runs only when ALU_TIMEOUT_EN is defined.
module tb_alu_operand_seq;

  localparam logic [7:0] OP_ADD = 8'h10;
  localparam logic [7:0] OP_SUB = 8'h20;
  localparam logic [7:0] OP_AND = 8'h30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic cmd_valid = 1'b0, din_valid = 1'b0, res_ready = 1'b0;
  logic [7:0] cmd_ir = 8'h00, din = 8'h00;
  logic cmd_ready, din_ready, res_valid;
  logic [7:0] res_data, alu_ir;
  logic res_carry, res_over, res_cmp, res_err;
  logic alu_start, alu_oe, alu_carryin;
  logic [15:0] alu_a, alu_b;
  logic alu_done, alu_carryout, alu_overout, alu_cmpo;
  logic [15:0] alu_aluout;

  alu_operand_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_over(res_over), .res_cmp(res_cmp),
    .res_err(res_err), .alu_start(alu_start), .alu_done(alu_done),
    .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_oe(alu_oe),
    .alu_carryin(alu_carryin), .alu_aluout(alu_aluout),
    .alu_carryout(alu_carryout), .alu_overout(alu_overout),
    .alu_cmpo(alu_cmpo)
  );

  // Behavioural ALU: done drops after start (or a mode opcode) for lat cycles.
  int lat = 2;
  logic stuck = 1'b0;
  int busy;
  logic cmode, mcin;
  logic [7:0] mop;
  logic [15:0] ma, mb;

  function automatic logic [17:0] alu_fn(input logic [7:0] op,
      input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic co, ov;
    co = 1'b0; ov = 1'b0; r = 16'h0;
    if (op == OP_ADD) begin
      s = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      r = s[15:0]; co = s[16];
      ov = (a[15] == b[15]) && (r[15] != a[15]);
    end else if (op == OP_SUB) begin
      r = a - b; co = (a < b);
      ov = (a[15] != b[15]) && (r[15] != a[15]);
    end else if (op == OP_AND) begin
      r = a & b;
    end
    return {co, ov, r};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      alu_done <= 1'b1; busy <= 0; cmode <= 1'b0; mcin <= 1'b0;
      alu_cmpo <= 1'b0; alu_aluout <= 16'h0;
      alu_carryout <= 1'b0; alu_overout <= 1'b0;
      mop <= 8'h00; ma <= 16'h0; mb <= 16'h0;
    end else if (alu_start && !stuck) begin
      alu_done <= 1'b0; busy <= lat;
      ma <= alu_a; mb <= alu_b; mop <= alu_ir;
      mcin <= alu_carryin & cmode;
      alu_cmpo <= (alu_ir == OP_SUB) && (alu_a == alu_b);
    end else if (busy == 0 && alu_ir >= 8'h51 && alu_ir <= 8'h54) begin
      alu_done <= 1'b0; busy <= lat; mop <= alu_ir;
      if (alu_ir == 8'h52) cmode <= 1'b1;
      if (alu_ir == 8'h51) cmode <= 1'b0;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        alu_done <= 1'b1; alu_cmpo <= 1'b0;
        if (mop < 8'h51 || mop > 8'h54)
          {alu_carryout, alu_overout, alu_aluout} <= alu_fn(mop, ma, mb, mcin);
      end
    end
  end

  int n_start = 0, n_ir52 = 0, n_din = 0, n_rv = 0;
  always @(negedge clk) begin
    if (alu_start) n_start++;
    if (alu_ir == 8'h52) n_ir52++;
    if (din_ready) n_din++;
    if (res_valid) n_rv++;
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] bv;
    int t;
    logic ok;
    bv = {b, a};
    ok = 1'b1;
    cmd_ir = op; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = bv[i*8 +: 8]; din_valid = 1'b1;
      t = 0;
      while (!din_ready && t < 100) begin @(negedge clk); t++; end
      if (!din_ready) ok = 1'b0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk("din_accept", 32'(ok), 32'd1);
  endtask

  task automatic recv(output logic [15:0] r);
    int t;
    logic ok;
    ok = 1'b1;
    r = 16'h0;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (!res_valid && t < 300) begin @(negedge clk); t++; end
      if (!res_valid || !alu_oe) ok = 1'b0;
      r[k*8 +: 8] = res_data;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    chk("res_handshake", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a, b, r;
    logic        c, o, m;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [15:0] r;
    logic [7:0] d0, d1;
    logic stable, saw0;
    int s0, s1, s2, s3, t, low;
    logic c_prev;

    vt[0] = '{OP_ADD, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0, 1'b0};
    vt[1] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[2] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0};
    vt[4] = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1};
    vt[5] = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vt[6] = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_ir", 32'(alu_ir), 32'h00);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_start_oe", {alu_start, alu_oe}, 32'd0);
    chk("rst_flags", {res_carry, res_over, res_cmp, res_err, alu_carryin}, 32'd0);
    chk("rst_operands", {alu_a, alu_b}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      s0 = n_start;
      send(vt[i].op, vt[i].a, vt[i].b);
      recv(r);
      chk($sformatf("v%0d_result", i), 32'(r), 32'(vt[i].r));
      chk($sformatf("v%0d_carry", i), 32'(res_carry), 32'(vt[i].c));
      chk($sformatf("v%0d_over", i), 32'(res_over), 32'(vt[i].o));
      chk($sformatf("v%0d_cmp", i), 32'(res_cmp), 32'(vt[i].m));
      chk($sformatf("v%0d_starts", i), 32'(n_start - s0), 32'd1);
    end

    // Mode op: carry-chain mode on.
    c_prev = res_carry;
    s0 = n_ir52; s1 = n_din; s2 = n_rv; s3 = n_start;
    cmd_ir = 8'h52; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    low = 0; saw0 = 1'b0; t = 0;
    while (!cmd_ready && t < 100) begin
      if (!alu_done) saw0 = 1'b1;
      low++;
      @(negedge clk);
      t++;
    end
    chk("mode_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mode_done_first", {saw0, alu_done}, 32'b11);
    chk("mode_busy_len", 32'(low >= 3), 32'd1);
    chk("mode_ir_cycles", 32'(n_ir52 - s0), 32'd1);
    chk("mode_no_din_res", 32'((n_din - s1) + (n_rv - s2) + (n_start - s3)), 32'd0);
    chk("mode_flags_kept", 32'(res_carry), 32'(c_prev));

    send(OP_ADD, 16'hFFFF, 16'h0001);
    recv(r);
    chk("chain1_result", 32'(r), 32'h0000);
    chk("chain1_carry", {res_carry, alu_carryin}, 32'b11);
    send(OP_ADD, 16'h0001, 16'h0002);
    recv(r);
    chk("chain2_cin_used", 32'(mcin), 32'd1);
    chk("chain2_result", 32'(r), 32'h0004);

    cmd_ir = 8'h51; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end

    // Back-pressure on the first result byte.
    send(OP_ADD, 16'h1234, 16'h0F0F);
    t = 0;
    while (!res_valid && t < 300) begin @(negedge clk); t++; end
    d0 = res_data; stable = res_valid;
    repeat (5) begin
      @(negedge clk);
      if (!res_valid || res_data !== d0) stable = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    t = 0;
    while (!res_valid && t < 300) begin @(negedge clk); t++; end
    d1 = res_data;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_bytes", {d0, d1}, 32'h4321);
    chk("bp_drained", {res_valid, cmd_ready}, 32'b01);

    // Reset while the ALU is busy.
    send(OP_ADD, 16'hFFFF, 16'h0001);
    recv(r);
    lat = 12;
    s0 = n_start;
    send(OP_ADD, 16'h1111, 16'h2222);
    t = 0;
    while (n_start == s0 && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {cmd_ready, res_valid, alu_start, alu_oe}, 32'b1000);
    chk("midrst_flags", {res_carry, res_over, res_cmp}, 32'd0);
    rst = 1'b0;
    lat = 2;
    send(OP_ADD, 16'h1111, 16'h2222);
    recv(r);
    chk("after_rst_result", 32'(r), 32'h3333);

`ifdef ALU_TIMEOUT_EN
    send(OP_ADD, 16'hFFFF, 16'h0001);
    recv(r);
    stuck = 1'b1;
    send(OP_ADD, 16'h1234, 16'h0F0F);
    recv(r);
    chk("tmo_result", 32'(r), 32'h0000);
    chk("tmo_err", 32'(res_err), 32'd1);
    chk("tmo_flags_kept", 32'(res_carry), 32'd1);
    stuck = 1'b0;
    send(OP_ADD, 16'h1234, 16'h0F0F);
    recv(r);
    chk("tmo_recover", {res_err, r}, 32'h02143);
`else
    chk("err_tied_low", 32'(res_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
